// File: rtl/pe_cfg_sequencer_pkg.sv
// Shared definitions for the per-PE configuration sequencer: state
// encodings, the NOP instruction and the default geometry.
package pe_cfg_sequencer_pkg;

    localparam int DEF_INST_W = 48;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ITER_W = 16;

    // All-zero word the PE decodes as "do nothing".
    localparam logic [DEF_INST_W-1:0] NOP_INST = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/pe_cfg_mem.sv
// DEPTH x INST_W program store: one synchronous write port and one
// asynchronous read port.
module pe_cfg_mem #(
    parameter int INST_W = 48,
    parameter int DEPTH  = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [INST_W-1:0] rdata
);

    logic [INST_W-1:0] mem [DEPTH];

    // Store an instruction on every enabled write.
    // NOTE: the array has no reset; the sequencer never reads a slot it has
    // not written, and leaving it out keeps this mappable onto RAM cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_cfg_sequencer.sv
// Per-PE configuration store and instruction sequencer: loads a program
// through a valid/ready port, then replays it (optionally several passes)
// into a registered instruction word for the PE datapath.
module pe_cfg_sequencer
    import pe_cfg_sequencer_pkg::*;
#(
    parameter int INST_W = DEF_INST_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int ITER_W = DEF_ITER_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INST_W-1:0] cfg_inst,
    input  logic              cfg_last,
    output logic              cfg_err,
    input  logic              run_start,
    input  logic [ITER_W-1:0] loop_count,
    input  logic              stall,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid,
    output logic              busy,
    output logic [PTR_W:0]    prog_len,
    output logic              done
);

    state_t            state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  iss_ptr;
    logic [PTR_W-1:0]  rd_addr;
    logic [ITER_W-1:0] iter;
    logic [INST_W-1:0] rd_data;
    logic              cfg_fire;
    logic              wr_en;
    logic              at_last;

    assign cfg_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign cfg_fire  = cfg_valid && cfg_ready;
    // rst and clear outrank a pending write, so the store must not see it.
    assign wr_en     = cfg_fire && !rst && !clear;
    assign busy      = (state == ST_RUN);
    assign at_last   = ({1'b0, iss_ptr} == prog_len - 1'b1);

    // Select the slot the output register loads next: slot 0 when starting
    // or wrapping to another pass, otherwise the following slot.
    // NOTE: rd_addr gets a default before any branch so no latch is inferred.
    always_comb begin
        rd_addr = '0;
        if (state == ST_RUN && !at_last) begin
            rd_addr = iss_ptr + 1'b1;
        end
    end

    pe_cfg_mem #(
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (cfg_inst),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Sequencer FSM with all registered outputs: load, replay, repeat, finish.
    // NOTE: every register here uses non-blocking assignment so all of them
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            iss_ptr    <= '0;
            iter       <= '0;
            prog_len   <= '0;
            cfg_err    <= 1'b0;
            inst_out   <= INST_W'(NOP_INST);
            inst_valid <= 1'b0;
            done       <= 1'b0;
        end else if (clear) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            iss_ptr    <= '0;
            iter       <= '0;
            prog_len   <= '0;
            cfg_err    <= 1'b0;
            inst_out   <= INST_W'(NOP_INST);
            inst_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_LOAD: begin
                    if (cfg_fire) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        state  <= ST_LOAD;
                        if (cfg_last) begin
                            prog_len <= {1'b0, wr_ptr} + 1'b1;
                            state    <= ST_READY;
                        end else if (wr_ptr == PTR_W'(DEPTH - 1)) begin
                            // Store is full with no terminator: close the
                            // program as-is and flag the error.
                            prog_len <= (PTR_W + 1)'(DEPTH);
                            cfg_err  <= 1'b1;
                            state    <= ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    if (run_start) begin
                        inst_out   <= rd_data;
                        inst_valid <= 1'b1;
                        iss_ptr    <= '0;
                        iter       <= loop_count;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (at_last && iter == '0) begin
                            inst_out   <= INST_W'(NOP_INST);
                            inst_valid <= 1'b0;
                            done       <= 1'b1;
                            state      <= ST_READY;
                        end else if (at_last) begin
                            iss_ptr  <= '0;
                            iter     <= iter - 1'b1;
                            inst_out <= rd_data;
                        end else begin
                            iss_ptr  <= iss_ptr + 1'b1;
                            inst_out <= rd_data;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_cfg_sequencer.sv
// Directed self-checking bench for pe_cfg_sequencer (DEPTH=4 instance).
module tb_pe_cfg_sequencer;

    localparam int INST_W = 48;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int ITER_W = 16;

    localparam logic [INST_W-1:0] I_A  = 48'hA000_0000_00A1;
    localparam logic [INST_W-1:0] I_B  = 48'hB000_0000_00B2;
    localparam logic [INST_W-1:0] I_C  = 48'hC000_0000_00C3;
    localparam logic [INST_W-1:0] I_X  = 48'h1111_2222_3333;
    localparam logic [INST_W-1:0] I_Y  = 48'h4444_5555_6666;
    localparam logic [INST_W-1:0] I_P  = 48'h7777_8888_9999;
    localparam logic [INST_W-1:0] I_D0 = 48'hD000_0000_0000;
    localparam logic [INST_W-1:0] I_D1 = 48'hD000_0000_0001;
    localparam logic [INST_W-1:0] I_D2 = 48'hD000_0000_0002;
    localparam logic [INST_W-1:0] I_D3 = 48'hD000_0000_0003;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INST_W-1:0] cfg_inst;
    logic              cfg_last;
    logic              cfg_err;
    logic              run_start;
    logic [ITER_W-1:0] loop_count;
    logic              stall;
    logic [INST_W-1:0] inst_out;
    logic              inst_valid;
    logic              busy;
    logic [PTR_W:0]    prog_len;
    logic              done;

    int checks   = 0;
    int failures = 0;

    pe_cfg_sequencer #(
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .ITER_W (ITER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_inst   (cfg_inst),
        .cfg_last   (cfg_last),
        .cfg_err    (cfg_err),
        .run_start  (run_start),
        .loop_count (loop_count),
        .stall      (stall),
        .inst_out   (inst_out),
        .inst_valid (inst_valid),
        .busy       (busy),
        .prog_len   (prog_len),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [INST_W-1:0] inst, input logic last);
        cfg_valid = 1'b1;
        cfg_inst  = inst;
        cfg_last  = last;
        tick();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic expect_inst(input string tag, input logic [INST_W-1:0] inst);
        check({tag, "_out"}, 64'(inst_out), 64'(inst));
        check({tag, "_vld"}, 64'(inst_valid), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_out"}, 64'(inst_out), 64'd0);
        check({tag, "_vld"}, 64'(inst_valid), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        tick();
        check({tag, "_done_drop"}, 64'(done), 64'd0);
    endtask

    task automatic start_run(input logic [ITER_W-1:0] loops);
        loop_count = loops;
        run_start  = 1'b1;
        tick();
        run_start  = 1'b0;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_out"}, 64'(inst_out), 64'd0);
        check({tag, "_vld"}, 64'(inst_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(cfg_err), 64'd0);
        check({tag, "_len"}, 64'(prog_len), 64'd0);
        check({tag, "_rdy"}, 64'(cfg_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; cfg_valid = 1'b0; cfg_inst = '0; cfg_last = 1'b0;
        run_start = 1'b0; loop_count = '0; stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        expect_idle("reset");

        // run_start in IDLE is ignored
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("idle_start_busy", 64'(busy), 64'd0);
        check("idle_start_vld", 64'(inst_valid), 64'd0);
        check("idle_start_rdy", 64'(cfg_ready), 64'd1);

        // Load A,B,C; run_start on the cfg_last edge is ignored
        load(I_A, 1'b0);
        check("load_a_rdy", 64'(cfg_ready), 64'd1);
        run_start = 1'b1;
        load(I_C - I_C + I_B, 1'b0);
        load(I_C, 1'b1);
        run_start = 1'b0;
        check("load_c_busy", 64'(busy), 64'd0);
        check("load_c_rdy", 64'(cfg_ready), 64'd0);
        check("load_c_len", 64'(prog_len), 64'd3);
        check("load_c_err", 64'(cfg_err), 64'd0);

        // Plain run, single pass
        start_run(16'd0);
        expect_inst("run1_a", I_A);
        tick();
        expect_inst("run1_b", I_B);
        tick();
        expect_inst("run1_c", I_C);
        tick();
        expect_done("run1_end");

        // Stall for 2 cycles while B is out
        start_run(16'd0);
        expect_inst("stl_a", I_A);
        tick();
        expect_inst("stl_b1", I_B);
        stall = 1'b1;
        tick();
        expect_inst("stl_b2", I_B);
        tick();
        expect_inst("stl_b3", I_B);
        stall = 1'b0;
        tick();
        expect_inst("stl_c", I_C);
        tick();
        expect_done("stl_end");

        // run_start during RUN is ignored
        start_run(16'd0);
        expect_inst("rr_a", I_A);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        expect_inst("rr_b", I_B);
        tick();
        expect_inst("rr_c", I_C);
        tick();
        expect_done("rr_end");

        // clear mid-RUN: back to IDLE, no done pulse
        start_run(16'd0);
        expect_inst("clr_a", I_A);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        expect_idle("clr");
        tick();
        check("clr_no_done", 64'(done), 64'd0);

        // X,Y with two extra passes; loop_count changes after start are ignored
        load(I_X, 1'b0);
        load(I_Y, 1'b1);
        check("xy_len", 64'(prog_len), 64'd2);
        for (int r = 0; r < 2; r++) begin
            start_run(16'd2);
            loop_count = 16'd0;
            for (int i = 0; i < 6; i++) begin
                expect_inst($sformatf("xy%0d_%0d", r, i), (i % 2 == 0) ? I_X : I_Y);
                tick();
            end
            expect_done($sformatf("xy%0d_end", r));
        end

        // rst mid-RUN, then a fresh load must land in slot 0
        start_run(16'd0);
        expect_inst("rst_x", I_X);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_idle("rst_mid");
        load(I_P, 1'b1);
        check("p_len", 64'(prog_len), 64'd1);
        start_run(16'd0);
        expect_inst("p_run", I_P);
        tick();
        expect_done("p_end");

        // Fill all 4 slots without cfg_last
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load(I_D0, 1'b0);
        load(I_D1, 1'b0);
        load(I_D2, 1'b0);
        check("full3_rdy", 64'(cfg_ready), 64'd1);
        check("full3_err", 64'(cfg_err), 64'd0);
        load(I_D3, 1'b0);
        check("full_rdy", 64'(cfg_ready), 64'd0);
        check("full_err", 64'(cfg_err), 64'd1);
        check("full_len", 64'(prog_len), 64'd4);
        start_run(16'd0);
        expect_inst("full_d0", I_D0);
        tick();
        expect_inst("full_d1", I_D1);
        tick();
        expect_inst("full_d2", I_D2);
        tick();
        expect_inst("full_d3", I_D3);
        tick();
        expect_done("full_end");
        check("full_err_sticky", 64'(cfg_err), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
